// File: rtl/display_select_sequencer.sv
// Steps the debug display mux through its eight sources, manually via debounced buttons or on a dwell timer.
// Latency: button press to select is 2 + DEBOUNCE_CYCLES + 2 cycles; state changes reach outputs on the next edge.
// Backpressure: none; display_valid drops for two edges after any select or enable change.
module display_select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        auto_mode,
  input  logic        blank,
  output logic [10:0] select,
  output logic        mux_enable,
  output logic        display_valid,
  output logic [2:0]  index
);

  typedef enum logic [1:0] {MANUAL, AUTO, BLANK} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync1, sync2, stable, stable_d, pulse;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] dwell, dwell_nxt;
  logic [2:0]       idx_nxt;
  logic [10:0]      sel_nxt;
  logic             en_nxt;
  logic             settle;
  logic             step_next, step_prev, btn_step;

  // Bit 0 carries the next button, bit 1 the prev button.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      pulse    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= {btn_prev, btn_next};
      sync2    <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign step_next = pulse[0] & ~pulse[1];
  assign step_prev = pulse[1] & ~pulse[0];
  assign btn_step  = pulse[0] ^ pulse[1];

  always_comb begin
    state_nxt = blank ? BLANK : (auto_mode ? AUTO : MANUAL);
    idx_nxt   = index;
    dwell_nxt = '0;
    case (state_nxt)
      MANUAL: begin
        if (step_next)      idx_nxt = index + 3'd1;
        else if (step_prev) idx_nxt = index - 3'd1;
      end
      AUTO: begin
        // A button step replaces the dwell step; entry into AUTO restarts the dwell.
        if (btn_step) begin
          idx_nxt = step_next ? index + 3'd1 : index - 3'd1;
        end else if (state == AUTO) begin
          if (dwell == CNT_W'(DWELL_CYCLES - 1)) idx_nxt = index + 3'd1;
          else                                   dwell_nxt = dwell + CNT_W'(1);
        end
      end
      default: ;
    endcase
    sel_nxt = (idx_nxt == 3'd0) ? 11'd0 : 11'd9 + {8'd0, idx_nxt};
    en_nxt  = (state_nxt == BLANK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= MANUAL;
      index         <= 3'd0;
      select        <= 11'd0;
      mux_enable    <= 1'b0;
      dwell         <= '0;
      settle        <= 1'b0;
      display_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      index      <= idx_nxt;
      select     <= sel_nxt;
      mux_enable <= en_nxt;
      dwell      <= dwell_nxt;
      // The mux registers select one edge later, so valid needs two quiet edges.
      if (sel_nxt != select || en_nxt != mux_enable || en_nxt) begin
        settle        <= 1'b0;
        display_valid <= 1'b0;
      end else begin
        settle        <= 1'b1;
        display_valid <= settle;
      end
    end
  end

endmodule

// File: tb/tb_display_select_sequencer.sv
// Directed bench for display_select_sequencer with short debounce and dwell times.
module tb_display_select_sequencer;

  logic        clock;
  logic        reset;
  logic        btn_next;
  logic        btn_prev;
  logic        auto_mode;
  logic        blank;
  logic [10:0] select;
  logic        mux_enable;
  logic        display_valid;
  logic [2:0]  index;

  int vectors = 0;
  int errors  = 0;

  display_select_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (8),
    .CNT_W          (26)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .auto_mode    (auto_mode),
    .blank        (blank),
    .select       (select),
    .mux_enable   (mux_enable),
    .display_valid(display_valid),
    .index        (index)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold the buttons for 10 cycles, release, and let the release debounce out.
  task automatic press(input logic n, input logic p);
    btn_next = n;
    btn_prev = p;
    cyc(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cyc(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_mode = 1'b0; blank = 1'b0;
    cyc(3);
    check("rst_select", select, 0);
    check("rst_index", index, 0);
    check("rst_mux_en", mux_enable, 0);
    check("rst_valid", display_valid, 0);
    reset = 1'b0;
    cyc(1);
    check("valid_edge1", display_valid, 0);
    cyc(1);
    check("valid_edge2", display_valid, 1);
    check("idle_select", select, 0);

    // First press: exact latency of 2 + 4 + 1 + 1 edges.
    btn_next = 1'b1;
    cyc(7);
    check("lat_before", select, 0);
    cyc(1);
    check("lat_select", select, 10);
    check("lat_index", index, 1);
    check("chg_valid0", display_valid, 0);
    cyc(2);
    check("chg_valid1", display_valid, 1);
    btn_next = 1'b0;
    cyc(10);

    for (int k = 2; k <= 7; k++) begin
      press(1'b1, 1'b0);
      check("next_select", select, 32'(9 + k));
    end
    press(1'b1, 1'b0);
    check("wrap_select", select, 0);
    check("wrap_index", index, 0);

    btn_next = 1'b1;
    cyc(2);
    btn_next = 1'b0;
    cyc(15);
    check("glitch_select", select, 0);

    press(1'b0, 1'b1);
    check("prev_select", select, 16);
    check("prev_index", index, 7);
    press(1'b1, 1'b1);
    check("both_select", select, 16);
    press(1'b1, 1'b0);
    check("back_to_0", select, 0);

    // Auto scan: the first posedge after this is A0.
    auto_mode = 1'b1;
    cyc(8);
    check("auto_hold0", select, 0);
    cyc(1);
    check("auto_step1", select, 10);
    cyc(6);
    btn_next = 1'b1;
    cyc(2);
    check("auto_step2", select, 11);
    cyc(5);
    check("btn_pending", select, 11);
    cyc(1);
    check("btn_step", select, 12);
    cyc(2);
    btn_next = 1'b0;
    cyc(5);
    check("dwell_restart", select, 12);
    cyc(1);
    check("dwell_step", select, 13);

    blank = 1'b1;
    cyc(1);
    check("blank_mux_en", mux_enable, 1);
    check("blank_valid", display_valid, 0);
    btn_next = 1'b1;
    cyc(10);
    btn_next = 1'b0;
    cyc(10);
    check("blank_select", select, 13);
    check("blank_valid_h", display_valid, 0);
    blank = 1'b0;
    cyc(1);
    check("unblank_mux", mux_enable, 0);
    check("unblank_v0", display_valid, 0);
    cyc(1);
    check("unblank_v1", display_valid, 0);
    cyc(1);
    check("unblank_v2", display_valid, 1);
    cyc(5);
    check("exit_hold", select, 13);
    cyc(1);
    check("exit_step", select, 14);
    cyc(8);
    check("auto_15", select, 15);

    btn_next = 1'b1;
    cyc(2);
    reset = 1'b1;
    auto_mode = 1'b0;
    cyc(1);
    check("mid_rst_select", select, 0);
    check("mid_rst_index", index, 0);
    check("mid_rst_valid", display_valid, 0);
    reset = 1'b0;
    btn_next = 1'b0;
    cyc(2);
    check("post_rst_valid", display_valid, 1);
    cyc(20);
    check("no_spurious", select, 0);
    check("manual_after", index, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
